// File: rtl/data_memory_arbiter.sv
// Round-robin arbiter sharing a byte-wide synchronous data RAM between the CPU MEM stage (C)
// and the loader (L); each 32-bit word access runs as four big-endian byte beats.
module data_memory_arbiter #(
  parameter int DM_SIZE = 1024,
  parameter int ADDR_W  = 10
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              c_req,
  input  logic              c_write,
  input  logic [31:0]       c_addr,
  input  logic [31:0]       c_wdata,
  output logic              c_done,
  output logic              c_err,
  output logic [31:0]       c_rdata,
  input  logic              l_req,
  input  logic              l_write,
  input  logic [31:0]       l_addr,
  input  logic [31:0]       l_wdata,
  output logic              l_done,
  output logic              l_err,
  output logic [31:0]       l_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata
);

  typedef enum logic [1:0] {IDLE, XFER, RWAIT, DONE} state_t;

  localparam logic        PORT_C    = 1'b0;
  localparam logic        PORT_L    = 1'b1;
  localparam logic [31:0] LAST_WORD = 32'(DM_SIZE - 4);

  state_t              state_q, state_d;
  logic [1:0]          beat_q, beat_d;
  logic                last_q, last_d;
  logic                gnt_q, gnt_d;
  logic                wr_q, wr_d;
  logic                err_q, err_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [31:0]         wdata_q, wdata_d;
  logic [31:0]         asm_q, asm_d;
  logic                mem_en_q, mem_en_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [7:0]          mem_wdata_q, mem_wdata_d;
  logic                c_done_q, c_done_d;
  logic                c_err_q, c_err_d;
  logic [31:0]         c_rdata_q, c_rdata_d;
  logic                l_done_q, l_done_d;
  logic                l_err_q, l_err_d;
  logic [31:0]         l_rdata_q, l_rdata_d;

  logic                grant_l;
  logic                sel_wr;
  logic [31:0]         sel_addr;
  logic [31:0]         sel_wdata;
  logic                bad_addr;
  logic [1:0]          nxt_beat;

  function automatic logic [7:0] word_byte(input logic [31:0] w, input logic [1:0] k);
    logic [7:0] b;
    case (k)
      2'd0:    b = w[31:24];
      2'd1:    b = w[23:16];
      2'd2:    b = w[15:8];
      default: b = w[7:0];
    endcase
    return b;
  endfunction

  function automatic logic [31:0] place_byte(input logic [31:0] w, input logic [1:0] k,
                                             input logic [7:0] b);
    logic [31:0] r;
    r = w;
    case (k)
      2'd0:    r[31:24] = b;
      2'd1:    r[23:16] = b;
      2'd2:    r[15:8]  = b;
      default: r[7:0]   = b;
    endcase
    return r;
  endfunction

  // Both requesting: the port that did not win last time gets the RAM.
  always_comb begin
    grant_l   = l_req && (!c_req || (last_q == PORT_C));
    sel_wr    = grant_l ? l_write : c_write;
    sel_addr  = grant_l ? l_addr  : c_addr;
    sel_wdata = grant_l ? l_wdata : c_wdata;
    bad_addr  = (sel_addr[1:0] != 2'b00) || (sel_addr > LAST_WORD);
    nxt_beat  = beat_q + 2'd1;
  end

  always_comb begin
    state_d     = state_q;
    beat_d      = beat_q;
    last_d      = last_q;
    gnt_d       = gnt_q;
    wr_d        = wr_q;
    err_d       = err_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    asm_d       = asm_q;
    mem_en_d    = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = '0;
    mem_wdata_d = '0;
    c_done_d    = 1'b0;
    c_err_d     = 1'b0;
    c_rdata_d   = c_rdata_q;
    l_done_d    = 1'b0;
    l_err_d     = 1'b0;
    l_rdata_d   = l_rdata_q;

    case (state_q)
      IDLE: begin
        if (c_req || l_req) begin
          gnt_d   = grant_l;
          last_d  = grant_l;
          wr_d    = sel_wr;
          addr_d  = sel_addr[ADDR_W-1:0];
          wdata_d = sel_wdata;
          err_d   = bad_addr;
          beat_d  = 2'd0;
          if (bad_addr) begin
            state_d = DONE;
          end else begin
            state_d     = XFER;
            mem_en_d    = 1'b1;
            mem_we_d    = sel_wr;
            mem_addr_d  = sel_addr[ADDR_W-1:0];
            mem_wdata_d = sel_wdata[31:24];
          end
        end
      end
      XFER: begin
        // Read data lags its beat by one cycle, so beat k lands byte k-1.
        if (!wr_q && (beat_q != 2'd0)) begin
          asm_d = place_byte(asm_q, beat_q - 2'd1, mem_rdata);
        end
        if (beat_q == 2'd3) begin
          beat_d  = 2'd0;
          state_d = wr_q ? DONE : RWAIT;
        end else begin
          beat_d      = nxt_beat;
          mem_en_d    = 1'b1;
          mem_we_d    = wr_q;
          mem_addr_d  = addr_q + ADDR_W'(nxt_beat);
          mem_wdata_d = word_byte(wdata_q, nxt_beat);
        end
      end
      RWAIT: begin
        asm_d   = place_byte(asm_q, 2'd3, mem_rdata);
        state_d = DONE;
      end
      DONE: begin
        // A rejected address dwells one extra cycle here so its done lands in cycle 3.
        if (err_q && (beat_q == 2'd0)) begin
          beat_d = 2'd1;
        end else begin
          state_d = IDLE;
          beat_d  = 2'd0;
          if (gnt_q == PORT_L) begin
            l_done_d = 1'b1;
            l_err_d  = err_q;
            if (!wr_q && !err_q) l_rdata_d = asm_q;
          end else begin
            c_done_d = 1'b1;
            c_err_d  = err_q;
            if (!wr_q && !err_q) c_rdata_d = asm_q;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      beat_q      <= 2'd0;
      last_q      <= PORT_L;
      gnt_q       <= PORT_C;
      wr_q        <= 1'b0;
      err_q       <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      asm_q       <= '0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      c_done_q    <= 1'b0;
      c_err_q     <= 1'b0;
      c_rdata_q   <= '0;
      l_done_q    <= 1'b0;
      l_err_q     <= 1'b0;
      l_rdata_q   <= '0;
    end else begin
      state_q     <= state_d;
      beat_q      <= beat_d;
      last_q      <= last_d;
      gnt_q       <= gnt_d;
      wr_q        <= wr_d;
      err_q       <= err_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      asm_q       <= asm_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      c_done_q    <= c_done_d;
      c_err_q     <= c_err_d;
      c_rdata_q   <= c_rdata_d;
      l_done_q    <= l_done_d;
      l_err_q     <= l_err_d;
      l_rdata_q   <= l_rdata_d;
    end
  end

  assign c_done    = c_done_q;
  assign c_err     = c_err_q;
  assign c_rdata   = c_rdata_q;
  assign l_done    = l_done_q;
  assign l_err     = l_err_q;
  assign l_rdata   = l_rdata_q;
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule
